// File: rtl/loba_pkg.sv
// Shared types and constants for the LOBA sequential multiplier: FSM states,
// term-count mode codes and the width helper for segment shift fields.
package loba_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } loba_state_e;

  localparam logic [1:0] LOBA_M_HH  = 2'd0;
  localparam logic [1:0] LOBA_M_HHL = 2'd1;
  localparam logic [1:0] LOBA_M_3T  = 2'd2;
  localparam logic [1:0] LOBA_M_4T  = 2'd3;

  // A segment shift never exceeds n-K < n, so clog2(n) bits always suffice.
  function automatic int loba_shw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/loba_seg_split.sv
// Splits one operand into high and low K-bit segments anchored at its leading
// one, plus the left shift that re-positions each segment.
module loba_seg_split
  import loba_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4,
  localparam int SHW = loba_shw(N)
) (
  input  logic [N-1:0]   i_x,
  output logic [K-1:0]   o_xh,
  output logic [SHW-1:0] o_sh,
  output logic [K-1:0]   o_xl,
  output logic [SHW-1:0] o_sl
);

  int w_h;
  int w_lo_h;
  int w_lo_l;
  int w_len;

  always_comb begin
    w_h    = 0;
    w_lo_h = 0;
    w_lo_l = 0;
    w_len  = 0;
    o_xh   = '0;
    o_sh   = '0;
    o_xl   = '0;
    o_sl   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_x[i]) w_h = i;
    end
    w_lo_h = (w_h >= K - 1) ? w_h - K + 1 : 0;
    // Bits above the leading one are zero, so the shifted value fits in K bits.
    o_xh   = K'(i_x >> w_lo_h);
    o_sh   = SHW'(w_lo_h);
    if (w_h >= K) begin
      w_lo_l = (w_h >= 2 * K - 1) ? w_h - 2 * K + 1 : 0;
      w_len  = w_h - K - w_lo_l + 1;
      o_xl   = K'((i_x >> w_lo_l) & ((N'(1) << w_len) - N'(1)));
      o_sl   = SHW'(w_lo_l);
    end
  end

endmodule

// File: rtl/loba_seq_mul.sv
// Handshake-driven LOBA approximate multiplier: one shared KxK multiplier
// accumulates 1..4 shifted segment products, one term per cycle.
module loba_seq_mul
  import loba_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy
);

  localparam int SHW = loba_shw(N);
  localparam int PW  = 2 * N;

  loba_state_e    r_state;
  logic [N-1:0]   r_a, r_b;
  logic [1:0]     r_mode, r_cnt;
  logic [K-1:0]   r_ah, r_al, r_bh, r_bl;
  logic [SHW-1:0] r_sha, r_sla, r_shb, r_slb;
  logic [PW-1:0]  r_acc;
  logic           r_in_ready, r_out_valid, r_busy;

  logic [K-1:0]   w_ah, w_al, w_bh, w_bl;
  logic [SHW-1:0] w_sha, w_sla, w_shb, w_slb;
  logic [K-1:0]   w_opa, w_opb;
  logic [SHW-1:0] w_sa, w_sb;
  logic [SHW:0]   w_sft;
  logic [2*K-1:0] w_prod;
  logic [PW-1:0]  w_term;

  loba_seg_split #(.N(N), .K(K)) u_split_a (
    .i_x (r_a), .o_xh(w_ah), .o_sh(w_sha), .o_xl(w_al), .o_sl(w_sla)
  );

  loba_seg_split #(.N(N), .K(K)) u_split_b (
    .i_x (r_b), .o_xh(w_bh), .o_sh(w_shb), .o_xl(w_bl), .o_sl(w_slb)
  );

  // Term order T0..T3 maps cnt[1] to A's segment and cnt[0] to B's segment.
  assign w_opa  = r_cnt[1] ? r_al  : r_ah;
  assign w_sa   = r_cnt[1] ? r_sla : r_sha;
  assign w_opb  = r_cnt[0] ? r_bl  : r_bh;
  assign w_sb   = r_cnt[0] ? r_slb : r_shb;
  assign w_sft  = {1'b0, w_sa} + {1'b0, w_sb};
  assign w_prod = {{K{1'b0}}, w_opa} * {{K{1'b0}}, w_opb};
  assign w_term = PW'(w_prod) << w_sft;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_acc;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= LOBA_M_HH;
      r_cnt       <= '0;
      r_ah        <= '0;
      r_al        <= '0;
      r_bh        <= '0;
      r_bl        <= '0;
      r_sha       <= '0;
      r_sla       <= '0;
      r_shb       <= '0;
      r_slb       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_mode     <= in_mode;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SPLIT;
          end
        end
        SPLIT: begin
          r_ah  <= w_ah;
          r_al  <= w_al;
          r_bh  <= w_bh;
          r_bl  <= w_bl;
          r_sha <= w_sha;
          r_sla <= w_sla;
          r_shb <= w_shb;
          r_slb <= w_slb;
          r_acc <= '0;
          r_cnt <= '0;
          if (r_a == '0 || r_b == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc <= r_acc + w_term;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == r_mode) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loba_seq_mul.sv
// Directed bench for loba_seq_mul: vector table, backpressure, mid-run reset
// and back-to-back transactions against a behavioural LOBA model.
module tb_loba_seq_mul;

  localparam int N = 16;
  localparam int K = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a, in_b;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [2*N-1:0] out_p;
  logic          busy;

  int checks = 0;
  int errors = 0;

  loba_seq_mul #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [1:0]     mode;
    logic [2*N-1:0] p;
    int             lat;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic split(input longint x, output longint xh, output longint sh,
                       output longint xl, output longint sl);
    int h;
    h  = -1;
    xh = 0; sh = 0; xl = 0; sl = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i] && h < 0) h = i;
    end
    if (h >= 0) begin
      sh = (h - K + 1 > 0) ? h - K + 1 : 0;
      xh = x >> sh;
      if (h >= K) begin
        sl = (h - 2 * K + 1 > 0) ? h - 2 * K + 1 : 0;
        xl = (x >> sl) % (64'd1 << (h - K - sl + 1));
      end
    end
  endtask

  task automatic ref_p(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [1:0] m, output longint p);
    longint ah, sha, al, sla, bh, shb, bl, slb;
    longint t[4];
    split(longint'(a), ah, sha, al, sla);
    split(longint'(b), bh, shb, bl, slb);
    t[0] = (ah * bh) << (sha + shb);
    t[1] = (ah * bl) << (sha + slb);
    t[2] = (al * bh) << (sla + shb);
    t[3] = (al * bl) << (sla + slb);
    p = 0;
    for (int i = 0; i <= int'(m); i++) p += t[i];
  endtask

  // Caller is at posedge+1 right after the accept edge; edges are counted
  // with the accept edge as the first one.
  task automatic wait_out(output logic [2*N-1:0] p, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = out_p;
  endtask

  task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [1:0] m, output logic [2*N-1:0] p,
                        output int lat);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(p, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*N-1:0] p;
    int             lat;
    int             cnt;
    longint         exp_p;
    logic [N-1:0]   ra, rb;
    logic [1:0]     rm;

    tv[0]  = '{16'hFFFF, 16'hFFFF, 2'd1, 32'hEF100000, 4};
    tv[1]  = '{16'hFFFF, 16'hFFFF, 2'd3, 32'hFE010000, 6};
    tv[2]  = '{16'hFFFF, 16'hFFFF, 2'd0, 32'hE1000000, 3};
    tv[3]  = '{16'h0005, 16'h0003, 2'd3, 32'd15,       6};
    tv[4]  = '{16'h0000, 16'h1234, 2'd2, 32'd0,        2};
    tv[5]  = '{16'hFFFF, 16'h0000, 2'd3, 32'd0,        2};
    tv[6]  = '{16'h00F0, 16'h0013, 2'd3, 32'h000011D0, 6};
    tv[7]  = '{16'h00F0, 16'h0013, 2'd0, 32'h000010E0, 3};
    tv[8]  = '{16'h1234, 16'h00FF, 2'd1, 32'h0011EE00, 4};
    tv[9]  = '{16'h1234, 16'h00FF, 2'd2, 32'h00120C00, 5};
    tv[10] = '{16'h1234, 16'h00FF, 2'd3, 32'h00120DE0, 6};
    tv[11] = '{16'h0001, 16'h0001, 2'd0, 32'd1,        3};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      do_txn(tv[i].a, tv[i].b, tv[i].mode, p, lat);
      chk($sformatf("v%0d_p", i), p, tv[i].p);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_1cyc", i), out_valid, 0);
    end

    // Backpressure: result must hold while a competing request waits.
    out_ready = 1'b0;
    do_txn(16'hFFFF, 16'hFFFF, 2'd1, p, lat);
    chk("bp_p", p, 32'hEF100000);
    chk("bp_lat", lat, 4);
    in_a = 16'h0005; in_b = 16'h0003; in_mode = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_p", out_p, 32'hEF100000);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_exit_valid", out_valid, 0);
    chk("bp_exit_no_accept", busy, 0);
    chk("bp_exit_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_next_accept", busy, 1);
    in_valid = 1'b0;
    wait_out(p, lat);
    chk("bp_next_p", p, 15);
    chk("bp_next_lat", lat, 6);
    @(posedge clk); #1;

    // Reset in the middle of MUL aborts the transaction.
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_mode = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_p", out_p, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(16'h8000, 16'h8000, 2'd0, p, lat);
    chk("mr_after_p", p, 32'h40000000);
    chk("mr_after_lat", lat, 3);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high; operands scrambled while busy.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom_range(1, 65535));
      rb = 16'($urandom_range(1, 65535));
      rm = 2'($urandom_range(0, 3));
      cnt = 0;
      while (!in_ready && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk($sformatf("b2b%0d_ready", k), in_ready, 1);
      in_a = ra; in_b = rb; in_mode = rm;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_accept", k), busy, 1);
      in_a = 16'($urandom); in_b = 16'($urandom); in_mode = 2'($urandom);
      wait_out(p, lat);
      ref_p(ra, rb, rm, exp_p);
      chk($sformatf("b2b%0d_p a=%0h b=%0h m=%0d", k, ra, rb, rm), p, exp_p);
      chk($sformatf("b2b%0d_lat", k), lat, int'(rm) + 3);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("end_idle", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
